// File: rtl/spi_pkg.sv
// Shared SPI definitions used by spi_master and spi_slave_rx: mode constants,
// FSM encoding and default sizing.
package spi_pkg;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_drop
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  do_push, do_pop;

  assign full    = (level_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);
  assign wr_drop = wr_en & ~do_push;

  assign level   = level_q;
  assign rd_data = rd_data_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    // Pointers are exactly ADDR_WIDTH bits, so increments wrap on their own.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode 0 receiver: synchronises sclk/mosi/cs_n into clk, deserialises
// MSB-first words and queues them in a receive FIFO drained by a local consumer.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs_n,
  input  logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic                  rx_busy,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  logic sclk_meta, sclk_s, sclk_d;
  logic mosi_meta, mosi_s;
  logic cs_meta, cs_n_s;
  logic rise;

  logic [1:0]            sync_vld_q;
  logic                  armed_q, armed_d;
  logic [0:0]            state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  push;
  logic                  ferr_q, ferr_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_drop;

  // Synchronisers reset to the idle line state so no false edge appears at release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta  <= 1'b0;
      sclk_s     <= 1'b0;
      sclk_d     <= 1'b0;
      mosi_meta  <= 1'b0;
      mosi_s     <= 1'b0;
      cs_meta    <= 1'b1;
      cs_n_s     <= 1'b1;
      sync_vld_q <= 2'b00;
    end else begin
      sclk_meta  <= sclk;
      sclk_s     <= sclk_meta;
      sclk_d     <= sclk_s;
      mosi_meta  <= mosi;
      mosi_s     <= mosi_meta;
      cs_meta    <= cs_n;
      cs_n_s     <= cs_meta;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  assign rise    = sclk_s & ~sclk_d;
  assign rx_busy = ~cs_n_s;
  assign shifted = {shreg_q, mosi_s};

  // A frame may only start after cs_n_s has genuinely been seen high, so a frame
  // cut by reset is not resumed while cs_n stays low.
  assign armed_d = armed_q | (sync_vld_q[1] & cs_n_s);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && !cs_n_s) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_n_s) begin
          state_d   = ST_IDLE;
          ferr_d    = (bit_cnt_q != '0);
          bit_cnt_d = '0;
        end else if (rise) begin
          shreg_d = shifted[DATA_WIDTH-2:0];
          if (bit_cnt_q == LastBit) begin
            push      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear wins over a same-cycle drop.
  assign ovf_d = ovf_clr ? 1'b0 : (wr_drop ? 1'b1 : ovf_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

  sync_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (shifted),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .wr_drop (wr_drop)
  );

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: bit-banged SPI frames, scoreboard of
// expected FIFO words, and directed corner-case sequences.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       fifo_rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] fifo_rd_data;
  logic       fifo_empty, fifo_full, rx_busy, frame_err, overflow;
  logic [4:0] fifo_level;

  spi_slave_rx #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16),
    .ADDR_WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .mosi         (mosi),
    .cs_n         (cs_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_level   (fifo_level),
    .rx_busy      (rx_busy),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb_q[$];
  logic       model_ovf = 1'b0;
  logic [7:0] last_pop = 8'h00;
  int         ferr_cnt = 0;

  typedef struct {
    logic [7:0] data;
    int         exp_level;
  } vec_t;

  always @(posedge clk) if (frame_err === 1'b1) ferr_cnt++;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rd_data"}, fifo_rd_data, 8'h00);
    check({tag, " empty"}, fifo_empty, 1'b1);
    check({tag, " full"}, fifo_full, 1'b0);
    check({tag, " level"}, fifo_level, 5'd0);
    check({tag, " rx_busy"}, rx_busy, 1'b0);
    check({tag, " frame_err"}, frame_err, 1'b0);
    check({tag, " overflow"}, overflow, 1'b0);
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    tick(4);
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
  endtask

  // With pop_last set, fifo_rd_en is held exactly over the push cycle of the last bit.
  task automatic send_word(input logic [7:0] w, input bit pop_last);
    logic [7:0] exp;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && pop_last) begin
        mosi = w[0];
        tick(4);
        sclk = 1'b1;
        tick(2);
        fifo_rd_en = 1'b1;
        tick(1);
        fifo_rd_en = 1'b0;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        check("pop during full push", fifo_rd_data, exp);
        tick(1);
        sclk = 1'b0;
      end else begin
        spi_bit(w[i]);
      end
    end
    if (pop_last) sb_q.push_back(w);
    else if (sb_q.size() < 16) sb_q.push_back(w);
    else model_ovf = 1'b1;
  endtask

  task automatic begin_frame();
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic end_frame();
    tick(4);
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] exp;
    fifo_rd_en = 1'b1;
    tick(1);
    fifo_rd_en = 1'b0;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got pop expected no scoreboard entry", name);
    end else begin
      exp = sb_q.pop_front();
      last_pop = exp;
      check(name, fifo_rd_data, exp);
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   ferr0;
    vecs[0] = '{8'hA5, 1};
    vecs[1] = '{8'h3C, 2};
    vecs[2] = '{8'h00, 3};
    vecs[3] = '{8'hFF, 4};
    vecs[4] = '{8'h81, 5};

    // Reset state
    rst_n = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(4);

    // Table-driven words in one frame (A5, 3C first as in loopback)
    ferr0 = ferr_cnt;
    begin_frame();
    check("rx_busy in frame", rx_busy, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_word(vecs[i].data, 1'b0);
      check("level after word", fifo_level, vecs[i].exp_level);
    end
    end_frame();
    check("rx_busy after frame", rx_busy, 1'b0);
    check("no frame_err clean", ferr_cnt - ferr0, 0);
    for (int i = 0; i < 5; i++) pop_check("table pop");
    check("empty after table", fifo_empty, 1'b1);

    // Frame abort after 5 bits
    ferr0 = ferr_cnt;
    begin_frame();
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
    end_frame();
    check("abort frame_err pulses", ferr_cnt - ferr0, 1);
    check("abort level", fifo_level, 5'd0);
    begin_frame();
    send_word(8'h5A, 1'b0);
    end_frame();
    pop_check("after abort pop");
    check("after abort empty", fifo_empty, 1'b1);

    // Overflow: 17 words, no reads
    begin_frame();
    for (int i = 0; i <= 16; i++) send_word(8'(i), 1'b0);
    end_frame();
    check("ovf full", fifo_full, 1'b1);
    check("ovf level", fifo_level, 5'd16);
    check("ovf flag", overflow, model_ovf);
    for (int i = 0; i < 16; i++) pop_check("ovf pop");
    check("ovf empty", fifo_empty, 1'b1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    model_ovf = 1'b0;
    check("ovf cleared", overflow, 1'b0);

    // Full FIFO with pop in the push cycle of EE
    begin_frame();
    for (int i = 0; i < 16; i++) send_word(8'h20 + 8'(i), 1'b0);
    check("pre-EE full", fifo_full, 1'b1);
    send_word(8'hEE, 1'b1);
    end_frame();
    check("full push+pop level", fifo_level, 5'd16);
    check("full push+pop ovf", overflow, 1'b0);
    for (int i = 0; i < 16; i++) pop_check("drain pop");
    check("EE last popped", last_pop, 8'hEE);

    // Pop while empty
    fifo_rd_en = 1'b1;
    tick(1);
    fifo_rd_en = 1'b0;
    tick(1);
    check("empty pop level", fifo_level, 5'd0);
    check("empty pop data held", fifo_rd_data, last_pop);

    // Reset mid-word; cs_n held low through release must not restart a frame
    begin_frame();
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    mosi = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    sb_q.delete();
    model_ovf = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    for (int i = 0; i < 8; i++) spi_bit(1'b1);
    tick(4);
    check("no resume after reset", fifo_level, 5'd0);
    cs_n = 1'b1;
    tick(6);
    begin_frame();
    send_word(8'h81, 1'b0);
    end_frame();
    check("post reset level", fifo_level, 5'd1);
    pop_check("post reset pop");
    check("post reset empty", fifo_empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
